// File: rtl/exec_stage_pkg.sv
// rtl/exec_stage_pkg.sv - shared opcodes, instruction field positions, FSM states for exec_stage
package exec_stage_pkg;

  localparam int NREGS = 16;
  localparam int XLEN  = 32;
  localparam int REGW  = $clog2(NREGS);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// rtl/exec_regfile.sv - N x W register file, two async reads, one sync write, r0 hardwired to zero
module exec_regfile
  import exec_stage_pkg::*;
#(
  parameter int N  = NREGS,
  parameter int W  = XLEN,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [W-1:0]  rdata2_o
);

  logic [W-1:0] regs_q [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - single-issue execute stage: decode, ALU, branch, load/store, retire flags
// Define EXEC_PERFCNT_EN to add the retire_count output.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] instr_pc,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            retire,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            illegal,
  output logic            addr_err,
  output logic            halted
`ifdef EXEC_PERFCNT_EN
  ,
  output logic [XLEN-1:0] retire_count
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, pc_q;
  logic            retire_q, redirect_q, illegal_q, addr_err_q, halted_q;
  logic            retire_d, redirect_d, illegal_d, addr_err_d, halted_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;

  logic [3:0]      op;
  logic [REGW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_sx, rs1_val, rs2_val, eff_addr;
  logic [XLEN-1:0] alu_res, pc_inc, exec_next_pc;
  logic            alu_we, br_taken, is_illegal, is_lw, is_sw, aligned, in_exec, in_load;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  assign op     = instr_q[OP_LSB +: 4];
  assign rd     = instr_q[RD_LSB +: REGW];
  assign rs1    = instr_q[RS1_LSB +: REGW];
  assign rs2    = instr_q[RS2_LSB +: REGW];
  assign imm_sx = sext16(instr_q[IMM_LSB +: 16]);

  exec_regfile #(.N(NREGS), .W(XLEN)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (rf_we),
    .waddr_i  (rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1),
    .rdata1_o (rs1_val),
    .raddr2_i (rs2),
    .rdata2_o (rs2_val)
  );

  assign in_exec  = (state_q == ST_EXEC);
  assign in_load  = (state_q == ST_LOAD);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign eff_addr = rs1_val + imm_sx;
  assign aligned  = (eff_addr[1:0] == 2'b00);
  assign pc_inc   = pc_q + 32'd1;

  always_comb begin
    alu_res    = '0;
    alu_we     = 1'b0;
    br_taken   = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = rs1_val + rs2_val; alu_we = 1'b1; end
      OP_SUB:  begin alu_res = rs1_val - rs2_val; alu_we = 1'b1; end
      OP_ADDI: begin alu_res = rs1_val + imm_sx;  alu_we = 1'b1; end
      OP_BEQ:  br_taken = (rs1_val == rs2_val);
      OP_JMP:  br_taken = 1'b1;
      OP_NOP, OP_LW, OP_SW, OP_HALT: ;
      default: is_illegal = 1'b1;
    endcase
  end

  assign exec_next_pc = br_taken ? (pc_q + imm_sx) : pc_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_lw && aligned)    state_d = ST_LOAD;
        else if (op == OP_HALT)  state_d = ST_HALTED;
        else                     state_d = ST_IDLE;
      end
      ST_LOAD:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // instr_ready is masked by reset so every output reads 0 while reset is held
  always_comb begin
    instr_ready = (state_q == ST_IDLE) && !reset;
    mem_re      = in_exec && is_lw && aligned;
    mem_we      = in_exec && is_sw && aligned;
    mem_addr    = (in_exec && (is_lw || is_sw)) ? eff_addr : '0;
    mem_wdata   = (in_exec && is_sw) ? rs2_val : '0;
    rf_we       = (in_exec && alu_we) || in_load;
    rf_wdata    = in_load ? mem_rdata : alu_res;
  end

  // LOAD only follows an aligned LW, so exec_next_pc is pc+1 there
  always_comb begin
    retire_d   = (in_exec && !(is_lw && aligned)) || in_load;
    next_pc_d  = retire_d ? exec_next_pc : next_pc_q;
    redirect_d = retire_d && (exec_next_pc != pc_inc);
    illegal_d  = retire_d && is_illegal;
    addr_err_d = in_exec && (is_lw || is_sw) && !aligned;
    halted_d   = halted_q || (in_exec && (op == OP_HALT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      pc_q       <= '0;
      retire_q   <= 1'b0;
      next_pc_q  <= '0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      addr_err_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && instr_valid) begin
        instr_q <= instr;
        pc_q    <= instr_pc;
      end
      retire_q   <= retire_d;
      next_pc_q  <= next_pc_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
      addr_err_q <= addr_err_d;
      halted_q   <= halted_d;
    end
  end

  assign retire   = retire_q;
  assign next_pc  = next_pc_q;
  assign redirect = redirect_q;
  assign illegal  = illegal_q;
  assign addr_err = addr_err_q;
  assign halted   = halted_q;

`ifdef EXEC_PERFCNT_EN
  logic [XLEN-1:0] retire_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         retire_count_q <= '0;
    else if (retire_d) retire_count_q <= retire_count_q + 32'd1;
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - randomized self-checking bench for exec_stage against an instruction-level model
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        retire, redirect, illegal, addr_err, halted;
  logic [31:0] next_pc;
`ifdef EXEC_PERFCNT_EN
  logic [31:0] retire_count;
`endif

  always #5 clk = ~clk;

  exec_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .retire      (retire),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .illegal     (illegal),
    .addr_err    (addr_err),
    .halted      (halted)
`ifdef EXEC_PERFCNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  typedef struct {
    logic [31:0] next_pc;
    logic        redirect, illegal, addr_err, re, we, halt;
    logic [31:0] addr, wdata;
    int          lat;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_ret = 0;
  exp_t        exp_q[$];
  logic [31:0] m_reg [16];
  logic [31:0] m_mem [64];
  logic [31:0] env_mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    exp_q.delete();
    n_ret = 0;
  endtask

  task automatic wr(input int rd, input logic [31:0] v);
    if (rd != 0) m_reg[rd] = v;
  endtask

  // Instruction-level semantics: one call = one architectural instruction
  task automatic model_step(input logic [31:0] ins, input logic [31:0] pc, output exp_t e);
    int op, rd, rs1, rs2;
    logic [31:0] a, b, sx;
    op = int'(ins[31:28]); rd = int'(ins[27:24]); rs1 = int'(ins[23:20]); rs2 = int'(ins[19:16]);
    a = m_reg[rs1]; b = m_reg[rs2];
    sx = 32'(signed'(ins[15:0]));
    e = '{next_pc: pc + 1, redirect: 0, illegal: 0, addr_err: 0, re: 0, we: 0, halt: 0,
          addr: 0, wdata: 0, lat: 2};
    case (op)
      0: ;
      1: wr(rd, a + b);
      2: wr(rd, a - b);
      3: wr(rd, a + sx);
      4: begin
        e.addr = a + sx;
        if (e.addr % 4 != 0) e.addr_err = 1;
        else begin e.re = 1; e.lat = 3; wr(rd, m_mem[(e.addr / 4) % 64]); end
      end
      5: begin
        e.addr = a + sx; e.wdata = b;
        if (e.addr % 4 != 0) e.addr_err = 1;
        else begin e.we = 1; m_mem[(e.addr / 4) % 64] = b; end
      end
      6: if (a == b) e.next_pc = pc + sx;
      7: e.next_pc = pc + sx;
      15: e.halt = 1;
      default: e.illegal = 1;
    endcase
    e.redirect = (e.next_pc != pc + 1);
  endtask

  // Called at a negedge with the stage idle; returns at the negedge where retire is seen
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output exp_t e);
    int cnt;
    check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr = ins; instr_pc = pc; instr_valid = 1'b1;
    model_step(ins, pc, e);
    exp_q.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom; instr_pc = $urandom;
    check("exec_mem_re", {31'd0, mem_re}, {31'd0, e.re});
    check("exec_mem_we", {31'd0, mem_we}, {31'd0, e.we});
    if (e.re || e.we) check("exec_mem_addr", mem_addr, e.addr);
    if (e.we) check("exec_mem_wdata", mem_wdata, e.wdata);
    cnt = 1;
    while (!retire && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("retire_latency", 32'(cnt), 32'(e.lat));
  endtask

  // Data memory environment, independent of the model's memory image
  always @(negedge clk) begin
    if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
    if (mem_re) mem_rdata = env_mem[mem_addr[7:2]];
  end

  // Retire compare process
  always @(negedge clk) begin
    exp_t e;
    if (!reset && retire) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_retire: got retire=1 expected retire=0");
      end else begin
        e = exp_q.pop_front();
        n_ret++;
        check("next_pc", next_pc, e.next_pc);
        check("redirect", {31'd0, redirect}, {31'd0, e.redirect});
        check("illegal", {31'd0, illegal}, {31'd0, e.illegal});
        check("addr_err", {31'd0, addr_err}, {31'd0, e.addr_err});
        check("halted", {31'd0, halted}, {31'd0, e.halt});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd0);
    check({tag, "_retire"}, {31'd0, retire}, 32'd0);
    check({tag, "_flags"}, {28'd0, redirect, illegal, addr_err, halted}, 32'd0);
    check({tag, "_next_pc"}, next_pc, 32'd0);
    check({tag, "_mem"}, {30'd0, mem_re, mem_we} | mem_addr | mem_wdata, 32'd0);
  endtask

  initial begin
    exp_t e;
    int op, rd, rs1, rs2, imm, sel;
    logic [31:0] pc;

    reset = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin env_mem[i] = 0; m_mem[i] = 0; end
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // Directed sequence with hand-computed values pinning the model
    issue(enc(3, 1, 0, 0, 5), 0, e);
    issue(enc(3, 2, 0, 0, -3), 1, e);
    check("model_addi_neg_next_pc", e.next_pc, 32'd2);
    issue(enc(1, 3, 1, 2, 0), 2, e);
    issue(enc(5, 0, 0, 3, 8), 3, e);
    check("lit_add_r3", e.wdata, 32'd2);
    check("lit_sw_addr", e.addr, 32'h8);
    issue(enc(3, 1, 0, 0, 1), 4, e);
    issue(enc(2, 4, 0, 1, 0), 5, e);
    issue(enc(5, 0, 0, 4, 12), 6, e);
    check("lit_sub_r4", e.wdata, 32'hFFFF_FFFF);
    issue(enc(3, 0, 0, 0, 7), 7, e);
    issue(enc(5, 0, 0, 0, 16), 8, e);
    check("lit_r0_zero", e.wdata, 32'd0);
    issue(enc(5, 0, 0, 1, 8), 9, e);
    env_mem[2] = 32'hDEAD_BEEF; m_mem[2] = 32'hDEAD_BEEF;
    issue(enc(4, 5, 0, 0, 8), 10, e);
    check("lit_lw_latency", 32'(e.lat), 32'd3);
    issue(enc(5, 0, 0, 5, 20), 11, e);
    check("lit_lw_r5", e.wdata, 32'hDEAD_BEEF);
    issue(enc(4, 5, 0, 0, 6), 12, e);
    check("lit_lw_misaligned", {31'd0, e.addr_err}, 32'd1);
    issue(enc(5, 0, 0, 5, 20), 13, e);
    check("lit_r5_unchanged", e.wdata, 32'hDEAD_BEEF);
    issue(enc(6, 0, 1, 1, -4), 20, e);
    check("lit_beq_taken", e.next_pc, 32'd16);
    issue(enc(6, 0, 1, 2, -4), 20, e);
    check("lit_beq_not_taken", e.next_pc, 32'd21);
    issue(enc(7, 0, 0, 0, 0), 32'hFFFF_FFFF, e);
    issue(enc(0, 0, 0, 0, 0), 32'hFFFF_FFFF, e);
    check("lit_pc_wrap", e.next_pc, 32'd0);
    issue(enc(9, 6, 1, 1, 0), 30, e);
    check("lit_illegal", {31'd0, e.illegal}, 32'd1);
    issue(enc(5, 0, 0, 6, 24), 31, e);
    check("lit_illegal_no_write", e.wdata, 32'd0);

    // Randomized instruction stream
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 10);
      op  = (sel <= 7) ? sel : (sel == 8) ? $urandom_range(8, 14) : 3;
      rd  = $urandom_range(0, 15); rs1 = $urandom_range(0, 15); rs2 = $urandom_range(0, 15);
      imm = $urandom_range(0, 65535);
      if (op == 4 || op == 5) begin
        if ($urandom_range(0, 1) == 1) rs1 = 0;
        imm = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) imm = imm - (imm % 4);
      end
      if (op == 6 && $urandom_range(0, 1) == 1) rs2 = rs1;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      issue(enc(op, rd, rs1, rs2, imm), pc, e);
    end
`ifdef EXEC_PERFCNT_EN
    check("retire_count", retire_count, 32'(n_ret));
`endif

    // Reset while an aligned LW sits in LOAD
    issue(enc(3, 5, 0, 0, 77), 40, e);
    instr = enc(4, 5, 0, 0, 0); instr_pc = 41; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("load_mem_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("midload_reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midload", {31'd0, instr_ready}, 32'd1);
    check("no_retire_after_midload", {31'd0, retire}, 32'd0);
    issue(enc(5, 0, 0, 5, 0), 50, e);
    check("lit_r5_cleared", e.wdata, 32'd0);

    // HALT is absorbing while instr_valid stays high
    issue(enc(15, 0, 0, 0, 0), 60, e);
    instr = enc(3, 1, 0, 0, 9); instr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("halt_ready", {31'd0, instr_ready}, 32'd0);
      check("halt_sticky", {31'd0, halted, retire}, 32'd2);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("halt_cleared", {31'd0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
